// File: rtl/rx_mem_pkg.sv
// ---------------------------------------------------------------------------
// rx_mem_pkg
// Shared types and constants for the receive-side frame memory controller:
//   - rx_state_t   : controller FSM states
//   - HDR_BYTES    : segment header length (aux, segment_num[15:8],
//                    segment_num[7:0], txid)
//   - *_OFS        : byte offsets of each header field
//   - CNT_W        : width of segment numbers and statistics counters
//   - sat_inc()    : saturating increment for the statistics counters
// ---------------------------------------------------------------------------
package rx_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP,
    CHECK
  } rx_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int HDR_CNT_W  = $clog2(HDR_BYTES);

  localparam int AUX_OFS    = 0;
  localparam int SEG_HI_OFS = 1;
  localparam int SEG_LO_OFS = 2;
  localparam int TXID_OFS   = 3;

  localparam int CNT_W      = 16;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_seg_addr_gen.sv
// ---------------------------------------------------------------------------
// rx_seg_addr_gen
// BRAM address generator for one segment. On load_base the segment base
// address (seg_num * PAYLOAD_BYTES) is registered and the byte offset is
// cleared; each byte_en advances the offset. A write request (wr_en) produces
// a registered strobe and address (base + offset) one cycle later.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_base    capture base for seg_num, clear offset
//   seg_num      segment number of the frame being received
//   byte_en      one payload byte consumed (written or not)
//   wr_en        current payload byte is to be written
//   offset       payload bytes consumed so far; saturates at PAYLOAD_BYTES+1
//   bram_addr    registered BRAM byte address
//   bram_we      registered BRAM write strobe
// ---------------------------------------------------------------------------
module rx_seg_addr_gen
  import rx_mem_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 1280,
  parameter int ADDR_W        = 24,
  parameter int OFS_W         = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base,
  input  logic [CNT_W-1:0]  seg_num,
  input  logic              byte_en,
  input  logic              wr_en,
  output logic [OFS_W-1:0]  offset,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we
);

  localparam logic [ADDR_W-1:0] PAYLOAD_LEN = ADDR_W'(PAYLOAD_BYTES);
  // One past a full payload is enough to tell "exact" from "too long".
  localparam logic [OFS_W-1:0]  OFS_SAT     = OFS_W'(PAYLOAD_BYTES + 1);

  logic [ADDR_W-1:0] base_q;

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      offset    <= '0;
      bram_addr <= '0;
      bram_we   <= 1'b0;
    end else begin
      bram_we <= wr_en;
      // The base is loaded on the last header byte, so it is stable before
      // the first payload byte arrives.
      if (load_base) begin
        base_q <= ADDR_W'(seg_num) * PAYLOAD_LEN;
        offset <= '0;
      end else if (byte_en && (offset != OFS_SAT)) begin
        offset <= offset + OFS_W'(1);
      end
      if (wr_en) begin
        bram_addr <= base_q + ADDR_W'(offset);
      end
    end
  end

endmodule

// File: rtl/rx_memory_control.sv
// ---------------------------------------------------------------------------
// rx_memory_control
// Receive-side frame memory controller. Parses the segment header from the
// de-framed payload stream, writes pixel bytes into the frame BRAM at
// segment_num * PAYLOAD_BYTES + offset, drops out-of-range segments and
// redundant copies, commits segments with good FCS and exact length, and
// pulses oneframe_done when the last segment of a video frame is committed.
//
// Configuration macro:
//   RX_STATS_EN  defined   -> dup_count / err_count are live saturating counters
//                undefined -> both outputs are tied to zero
//
// Ports:
//   clk125MHz      sole clock
//   rst            asynchronous active-low reset
//   rx_data        payload byte
//   rx_valid       rx_data valid this cycle
//   rx_sop         first byte of frame (with rx_valid)
//   rx_eop         last byte of frame (with rx_valid)
//   rx_crc_ok      FCS good, sampled with rx_eop
//   bram_we        BRAM write strobe
//   bram_addr      BRAM byte address
//   bram_din       BRAM write data
//   seg_num_out    last committed segment number
//   txid_out       txid of last committed segment
//   oneframe_done  one-cycle pulse after segment MAX-1 is committed
//   busy           frame in progress (HDR/PAYLOAD/DROP/CHECK)
//   dup_count      duplicate frames dropped
//   err_count      errored / aborted frames
// ---------------------------------------------------------------------------
module rx_memory_control
  import rx_mem_pkg::*;
#(
  parameter int SEGMENT_NUMBER_MAX = 720,
  parameter int PAYLOAD_BYTES      = 1280,
  parameter int ADDR_W             = 24
) (
  input  logic              clk125MHz,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_crc_ok,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic [CNT_W-1:0]  seg_num_out,
  output logic [7:0]        txid_out,
  output logic              oneframe_done,
  output logic              busy,
  output logic [CNT_W-1:0]  dup_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int                OFS_W       = $clog2(PAYLOAD_BYTES + 2);
  localparam logic [OFS_W-1:0]  PAYLOAD_LEN = OFS_W'(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0]  SEG_MAX     = CNT_W'(SEGMENT_NUMBER_MAX);
  localparam logic [CNT_W-1:0]  SEG_LAST    = CNT_W'(SEGMENT_NUMBER_MAX - 1);

  rx_state_t state_q, state_n;

  logic [HDR_CNT_W-1:0] hdr_cnt_q;
  logic [7:0]           aux_q;
  logic [CNT_W-1:0]     seg_q;
  logic [7:0]           txid_q;
  logic                 crc_q;
  logic [CNT_W-1:0]     last_seg_q;
  logic [7:0]           last_aux_q;
  logic                 last_valid_q;
  logic [OFS_W-1:0]     offset;

  logic sop_in;
  logic hdr_start, hdr_take, load_base, byte_en, wr_en, crc_take;
  logic commit, done_n, err_inc, dup_inc;
  logic is_txid_byte, is_dup;

  assign sop_in       = rx_valid && rx_sop;
  assign is_txid_byte = (hdr_cnt_q == HDR_CNT_W'(TXID_OFS));
  assign is_dup       = last_valid_q && (seg_q == last_seg_q) && (aux_q == last_aux_q);
  assign busy         = (state_q != IDLE);

  // -------------------------------------------------------------------------
  // Next-state and control strobes
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state_q;
    hdr_start = 1'b0;
    hdr_take  = 1'b0;
    load_base = 1'b0;
    byte_en   = 1'b0;
    wr_en     = 1'b0;
    crc_take  = 1'b0;
    commit    = 1'b0;
    done_n    = 1'b0;
    err_inc   = 1'b0;
    dup_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sop_in) begin
          hdr_start = 1'b1;
          state_n   = HDR;
        end
      end

      HDR: begin
        if (sop_in) begin
          // Abort; the sop byte is the new frame's aux byte.
          err_inc   = 1'b1;
          hdr_start = 1'b1;
        end else if (rx_valid) begin
          if (rx_eop) begin
            err_inc = 1'b1;
            state_n = IDLE;
          end else begin
            hdr_take = 1'b1;
            // segment_num is complete by the txid byte, so decide now.
            if (is_txid_byte) begin
              if (seg_q >= SEG_MAX) begin
                err_inc = 1'b1;
                state_n = DROP;
              end else if (is_dup) begin
                dup_inc = 1'b1;
                state_n = DROP;
              end else begin
                load_base = 1'b1;
                state_n   = PAYLOAD;
              end
            end
          end
        end
      end

      PAYLOAD: begin
        if (sop_in) begin
          err_inc   = 1'b1;
          hdr_start = 1'b1;
          state_n   = HDR;
        end else if (rx_valid) begin
          byte_en = 1'b1;
          wr_en   = (offset < PAYLOAD_LEN);
          if (rx_eop) begin
            crc_take = 1'b1;
            state_n  = CHECK;
          end
        end
      end

      DROP: begin
        if (sop_in) begin
          err_inc   = 1'b1;
          hdr_start = 1'b1;
          state_n   = HDR;
        end else if (rx_valid && rx_eop) begin
          state_n = IDLE;
        end
      end

      CHECK: begin
        if (crc_q && (offset == PAYLOAD_LEN)) begin
          commit = 1'b1;
          done_n = (seg_q == SEG_LAST);
        end else begin
          err_inc = 1'b1;
        end
        // The previous frame is already resolved here, so a back-to-back sop
        // simply starts the next header.
        if (sop_in) begin
          hdr_start = 1'b1;
          state_n   = HDR;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, header fields, commit registers, write data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      hdr_cnt_q     <= '0;
      aux_q         <= '0;
      seg_q         <= '0;
      txid_q        <= '0;
      crc_q         <= 1'b0;
      last_seg_q    <= 16'hFFFF;
      last_aux_q    <= '0;
      last_valid_q  <= 1'b0;
      seg_num_out   <= '0;
      txid_out      <= '0;
      oneframe_done <= 1'b0;
      bram_din      <= '0;
    end else begin
      state_q       <= state_n;
      oneframe_done <= done_n;

      if (hdr_start) begin
        aux_q     <= rx_data;
        hdr_cnt_q <= HDR_CNT_W'(AUX_OFS + 1);
      end else if (hdr_take) begin
        unique case (hdr_cnt_q)
          HDR_CNT_W'(SEG_HI_OFS): seg_q[15:8] <= rx_data;
          HDR_CNT_W'(SEG_LO_OFS): seg_q[7:0]  <= rx_data;
          HDR_CNT_W'(TXID_OFS):   txid_q      <= rx_data;
          default: ;
        endcase
        hdr_cnt_q <= hdr_cnt_q + HDR_CNT_W'(1);
      end

      if (crc_take) crc_q <= rx_crc_ok;
      if (wr_en)    bram_din <= rx_data;

      if (commit) begin
        last_seg_q   <= seg_q;
        last_aux_q   <= aux_q;
        last_valid_q <= 1'b1;
        seg_num_out  <= seg_q;
        txid_out     <= txid_q;
      end
    end
  end

  rx_seg_addr_gen #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .ADDR_W        (ADDR_W),
    .OFS_W         (OFS_W)
  ) u_addr_gen (
    .clk       (clk125MHz),
    .rst_n     (rst),
    .load_base (load_base),
    .seg_num   (seg_q),
    .byte_en   (byte_en),
    .wr_en     (wr_en),
    .offset    (offset),
    .bram_addr (bram_addr),
    .bram_we   (bram_we)
  );

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef RX_STATS_EN
  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      dup_count <= '0;
      err_count <= '0;
    end else begin
      if (dup_inc) dup_count <= sat_inc(dup_count);
      if (err_inc) err_count <= sat_inc(err_count);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = dup_inc | err_inc;
  assign dup_count    = '0;
  assign err_count    = '0;
`endif

endmodule
